// File: rtl/dm_cache_ctrl_pkg.sv
// cache_pkg: cache geometry, FSM state encoding and CPU address field helpers
// shared by dm_cache_ctrl, its line array and the bus interface.
package cache_pkg;

  localparam int CACHE_LINE_WIDTH = 128;
  localparam int ADDR_WIDTH       = 32;
  localparam int DATA_WIDTH       = 32;
  localparam int NUM_LINES        = 8;
  localparam int OFFSET_W         = 2;
  localparam int INDEX_W          = $clog2(NUM_LINES);
  localparam int TAG_W            = ADDR_WIDTH - INDEX_W - OFFSET_W - 2;
  localparam int LINE_ADDR_W      = TAG_W + INDEX_W;
  localparam int MEM_ADDR_W       = 30;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WRITEBACK = 2'd1;
  localparam logic [1:0] ALLOCATE  = 2'd2;

  typedef enum logic [1:0] {
    WR_NONE,
    WR_WORD,
    WR_FILL
  } wr_mode_t;

  typedef struct packed {
    logic [TAG_W-1:0]    tag;
    logic [INDEX_W-1:0]  index;
    logic [OFFSET_W-1:0] offset;
  } addr_fields_t;

  // Byte address layout: {tag, index, word offset, 2'b byte}
  function automatic addr_fields_t split_addr(input logic [ADDR_WIDTH-1:0] addr);
    addr_fields_t f;
    f.tag    = addr[ADDR_WIDTH-1 -: TAG_W];
    f.index  = addr[2+OFFSET_W +: INDEX_W];
    f.offset = addr[2 +: OFFSET_W];
    return f;
  endfunction

endpackage

// File: rtl/dm_cache_ctrl_if.sv
// dm_cache_ctrl_if: CPU load/store port plus data_mem line port of the cache.
// master = CPU/memory environment, slave = the cache controller.
interface dm_cache_ctrl_if;
  import cache_pkg::*;

  logic                        cpu_read;
  logic                        cpu_write;
  logic [ADDR_WIDTH-1:0]       cpu_addr;
  logic [DATA_WIDTH-1:0]       cpu_wdata;
  logic [DATA_WIDTH-1:0]       cpu_rdata;
  logic                        stall;
  logic                        mem_write;
  logic [MEM_ADDR_W-1:0]       mem_addr;
  logic [CACHE_LINE_WIDTH-1:0] mem_wdata;
  logic [CACHE_LINE_WIDTH-1:0] mem_rdata;

  modport master (
    output cpu_read, cpu_write, cpu_addr, cpu_wdata, mem_rdata,
    input  cpu_rdata, stall, mem_write, mem_addr, mem_wdata
  );

  modport slave (
    input  cpu_read, cpu_write, cpu_addr, cpu_wdata, mem_rdata,
    output cpu_rdata, stall, mem_write, mem_addr, mem_wdata
  );

endinterface

// File: rtl/dm_cache_ctrl_line_array.sv
// cache_line_array: tag/valid/dirty/data storage, one combinational read port and
// one posedge write port (word write, line fill); only valid/dirty are reset.
module cache_line_array
  import cache_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic [INDEX_W-1:0]          index,
  input  wr_mode_t                    wr_mode,
  input  logic [OFFSET_W-1:0]         wr_offset,
  input  logic [TAG_W-1:0]            wr_tag,
  input  logic [DATA_WIDTH-1:0]       wr_word,
  input  logic [CACHE_LINE_WIDTH-1:0] wr_line,
  output logic                        rd_valid,
  output logic                        rd_dirty,
  output logic [TAG_W-1:0]            rd_tag,
  output logic [CACHE_LINE_WIDTH-1:0] rd_line
);

  logic [NUM_LINES-1:0]        valid_q;
  logic [NUM_LINES-1:0]        dirty_q;
  logic [TAG_W-1:0]            tag_q  [NUM_LINES];
  logic [CACHE_LINE_WIDTH-1:0] data_q [NUM_LINES];

  assign rd_valid = valid_q[index];
  assign rd_dirty = dirty_q[index];
  assign rd_tag   = tag_q[index];
  assign rd_line  = data_q[index];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      case (wr_mode)
        WR_FILL: begin
          valid_q[index] <= 1'b1;
          dirty_q[index] <= 1'b0;
        end
        WR_WORD: dirty_q[index] <= 1'b1;
        default: ;
      endcase
    end
  end

  // Tag and data contents are meaningless until valid is set, so no reset here
  always_ff @(posedge clk) begin
    case (wr_mode)
      WR_FILL: begin
        tag_q[index]  <= wr_tag;
        data_q[index] <= wr_line;
      end
      WR_WORD: data_q[index][wr_offset*DATA_WIDTH +: DATA_WIDTH] <= wr_word;
      default: ;
    endcase
  end

endmodule

// File: rtl/dm_cache_ctrl.sv
// dm_cache_ctrl: direct-mapped, write-back, write-allocate cache in front of data_mem.
// Define CACHE_STATS_EN to add the hit_count/miss_count statistics ports.
module dm_cache_ctrl
  import cache_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  dm_cache_ctrl_if.slave bus
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]    hit_count,
  output logic [31:0]    miss_count
`endif
);

  logic [1:0]                  state;
  logic [1:0]                  state_next;
  addr_fields_t                req_f;
  logic [LINE_ADDR_W-1:0]      miss_line;
  logic [INDEX_W-1:0]          arr_index;
  logic                        line_valid;
  logic                        line_dirty;
  logic [TAG_W-1:0]            line_tag;
  logic [CACHE_LINE_WIDTH-1:0] line_data;
  wr_mode_t                    wr_mode;
  logic                        req;
  logic                        hit;
  logic                        miss_start;

  assign req_f      = split_addr(bus.cpu_addr);
  assign req        = bus.cpu_read | bus.cpu_write;
  // The miss line is latched so a dropped or changed request cannot redirect the fill
  assign arr_index  = (state == IDLE) ? req_f.index : miss_line[INDEX_W-1:0];
  assign hit        = line_valid && (line_tag == req_f.tag);
  assign miss_start = (state == IDLE) && req && !hit;

  assign bus.cpu_rdata = line_data[req_f.offset*DATA_WIDTH +: DATA_WIDTH];
  assign bus.mem_wdata = line_data;

  cache_line_array u_lines (
    .clk       (clk),
    .rst       (rst),
    .index     (arr_index),
    .wr_mode   (wr_mode),
    .wr_offset (req_f.offset),
    .wr_tag    (miss_line[LINE_ADDR_W-1 -: TAG_W]),
    .wr_word   (bus.cpu_wdata),
    .wr_line   (bus.mem_rdata),
    .rd_valid  (line_valid),
    .rd_dirty  (line_dirty),
    .rd_tag    (line_tag),
    .rd_line   (line_data)
  );

  always_comb begin
    state_next    = state;
    wr_mode       = WR_NONE;
    bus.stall     = 1'b0;
    bus.mem_write = 1'b0;
    bus.mem_addr  = '0;
    case (state)
      IDLE: begin
        if (miss_start) begin
          bus.stall  = 1'b1;
          state_next = (line_valid && line_dirty) ? WRITEBACK : ALLOCATE;
        end else if (bus.cpu_write && hit) begin
          wr_mode = WR_WORD;
        end
      end
      WRITEBACK: begin
        bus.stall     = 1'b1;
        bus.mem_write = 1'b1;
        bus.mem_addr  = MEM_ADDR_W'({line_tag, arr_index});
        state_next    = ALLOCATE;
      end
      ALLOCATE: begin
        bus.stall    = 1'b1;
        bus.mem_addr = MEM_ADDR_W'(miss_line);
        wr_mode      = WR_FILL;
        state_next   = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      miss_line <= '0;
    end else begin
      state <= state_next;
      if (miss_start) miss_line <= {req_f.tag, req_f.index};
    end
  end

`ifdef CACHE_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if ((state == IDLE) && req && hit) hit_count <= hit_count + 32'd1;
      if (miss_start) miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// tb_dm_cache_ctrl: directed vector bench for dm_cache_ctrl with a line-wide data_mem model.
`timescale 1ns/1ps
module tb_dm_cache_ctrl;
  import cache_pkg::*;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          stalls;
    bit          chk_rdata;
    logic [31:0] rdata;
    bit          exp_wb;
    logic [31:0] wb_addr;
    logic [31:0] wb_word;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic mem_load;
  int   checks = 0;
  int   failures = 0;
  int   exp_hits = 0;
  int   exp_misses = 0;
  vec_t vecs [11];
  logic [CACHE_LINE_WIDTH-1:0] mem_model [64];

`ifdef CACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  dm_cache_ctrl_if bus ();

  dm_cache_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus)
`ifdef CACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  always #5 clk = ~clk;

  // data_mem: combinational read, posedge line write; word0=3, word1=F0, word4=1, word32=4
  assign bus.mem_rdata = mem_model[bus.mem_addr[5:0]];

  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 64; i++) mem_model[i] <= '0;
      mem_model[0] <= {64'h0, 32'h0000_00F0, 32'h0000_0003};
      mem_model[1] <= 128'h1;
      mem_model[8] <= 128'h4;
    end else if (bus.mem_write) begin
      mem_model[bus.mem_addr[5:0]] <= bus.mem_wdata;
    end
  end

  function automatic vec_t mk(input logic rd, input logic wr, input logic [31:0] addr,
                              input logic [31:0] wdata, input int stalls, input bit chk,
                              input logic [31:0] rdata, input bit wb,
                              input logic [31:0] wb_addr, input logic [31:0] wb_word);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata; v.stalls = stalls;
    v.chk_rdata = chk; v.rdata = rdata; v.exp_wb = wb; v.wb_addr = wb_addr; v.wb_word = wb_word;
    return v;
  endfunction

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic check_stats(input string tag);
`ifdef CACHE_STATS_EN
    check_output({tag, "_hit_count"}, hit_count, 32'(exp_hits));
    check_output({tag, "_miss_count"}, miss_count, 32'(exp_misses));
`endif
  endtask

  // Drives one request from just after a posedge and holds it until the hit cycle completes
  task automatic apply_stimulus(input int id, input vec_t v);
    int          stalls;
    int          wb_cycles;
    logic [31:0] wb_addr;
    logic [31:0] wb_word;
    logic [31:0] rdata;
    bit          done;
    stalls = 0; wb_cycles = 0; wb_addr = '0; wb_word = '0; rdata = '0; done = 1'b0;
    bus.cpu_read  = v.rd;
    bus.cpu_write = v.wr;
    bus.cpu_addr  = v.addr;
    bus.cpu_wdata = v.wdata;
    for (int cyc = 0; cyc < 8 && !done; cyc++) begin
      @(negedge clk);
      if (!bus.stall) begin
        rdata = bus.cpu_rdata;
        done  = 1'b1;
      end else begin
        stalls++;
        if (bus.mem_write) begin
          wb_cycles++;
          wb_addr = 32'(bus.mem_addr);
          wb_word = bus.mem_wdata[31:0];
        end
      end
      @(posedge clk);
      #1;
    end
    bus.cpu_read  = 1'b0;
    bus.cpu_write = 1'b0;
    check_output($sformatf("v%0d_completed", id), 32'(done), 32'd1);
    check_output($sformatf("v%0d_stalls", id), 32'(stalls), 32'(v.stalls));
    check_output($sformatf("v%0d_wb_cycles", id), 32'(wb_cycles), v.exp_wb ? 32'd1 : 32'd0);
    if (v.chk_rdata) check_output($sformatf("v%0d_rdata", id), rdata, v.rdata);
    if (v.exp_wb) begin
      check_output($sformatf("v%0d_wb_addr", id), wb_addr, v.wb_addr);
      check_output($sformatf("v%0d_wb_word0", id), wb_word, v.wb_word);
    end
    exp_hits++;
    if (v.stalls > 0) exp_misses++;
  endtask

  initial begin
    vecs[0]  = mk(1, 0, 32'h00, 32'h0,          2, 1, 32'h0000_0003, 0, 32'h0, 32'h0);
    vecs[1]  = mk(1, 0, 32'h04, 32'h0,          0, 1, 32'h0000_00F0, 0, 32'h0, 32'h0);
    vecs[2]  = mk(1, 0, 32'h10, 32'h0,          2, 1, 32'h0000_0001, 0, 32'h0, 32'h0);
    vecs[3]  = mk(0, 1, 32'h00, 32'hDEAD_BEEF,  0, 0, 32'h0,         0, 32'h0, 32'h0);
    vecs[4]  = mk(1, 0, 32'h80, 32'h0,          3, 1, 32'h0000_0004, 1, 32'h0, 32'hDEAD_BEEF);
    vecs[5]  = mk(1, 0, 32'h00, 32'h0,          2, 1, 32'hDEAD_BEEF, 0, 32'h0, 32'h0);
    vecs[6]  = mk(1, 1, 32'h04, 32'h1234_5678,  0, 1, 32'h0000_00F0, 0, 32'h0, 32'h0);
    vecs[7]  = mk(1, 0, 32'h04, 32'h0,          0, 1, 32'h1234_5678, 0, 32'h0, 32'h0);
    vecs[8]  = mk(0, 1, 32'h90, 32'hA5A5_0001,  2, 0, 32'h0,         0, 32'h0, 32'h0);
    vecs[9]  = mk(1, 0, 32'h90, 32'h0,          0, 1, 32'hA5A5_0001, 0, 32'h0, 32'h0);
    vecs[10] = mk(1, 0, 32'h10, 32'h0,          3, 1, 32'h0000_0001, 1, 32'h9, 32'hA5A5_0001);

    mem_load      = 1'b1;
    rst           = 1'b0;
    bus.cpu_read  = 1'b0;
    bus.cpu_write = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    #2;
    check_output("reset_stall", 32'(bus.stall), 32'd0);
    check_output("reset_mem_write", 32'(bus.mem_write), 32'd0);
    check_output("reset_mem_addr", 32'(bus.mem_addr), 32'd0);
    check_stats("reset");
    @(negedge clk);
    @(negedge clk);
    mem_load = 1'b0;
    rst      = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 11; i++) apply_stimulus(i, vecs[i]);

    // Request dropped one cycle into a clean miss: fill must still land at 0x20
    bus.cpu_read = 1'b1;
    bus.cpu_addr = 32'h20;
    @(negedge clk);
    check_output("drop_idle_stall", 32'(bus.stall), 32'd1);
    @(posedge clk);
    #1;
    bus.cpu_read = 1'b0;
    bus.cpu_addr = 32'h44;
    @(negedge clk);
    check_output("drop_alloc_stall", 32'(bus.stall), 32'd1);
    check_output("drop_fill_addr", 32'(bus.mem_addr), 32'd2);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    exp_misses++;
    apply_stimulus(11, mk(1, 0, 32'h20, 32'h0, 0, 1, 32'h0, 0, 32'h0, 32'h0));
    check_stats("pre_reset");

    // Reset asserted while the dirty line 0 is being written back
    bus.cpu_read = 1'b1;
    bus.cpu_addr = 32'h80;
    @(posedge clk);
    #1;
    check_output("rstwb_mem_write_before", 32'(bus.mem_write), 32'd1);
    rst          = 1'b0;
    bus.cpu_read = 1'b0;
    #1;
    check_output("rstwb_mem_write_after", 32'(bus.mem_write), 32'd0);
    check_output("rstwb_mem_addr_after", 32'(bus.mem_addr), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    exp_hits   = 0;
    exp_misses = 0;
    apply_stimulus(12, mk(1, 0, 32'h80, 32'h0, 2, 1, 32'h0000_0004, 0, 32'h0, 32'h0));
    check_stats("post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
